// File: rtl/cdc_in_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdc_in_arbiter
// Purpose  : Packet-granular round-robin arbiter that shares the single
//            USB CDC bulk IN byte stream between N_REQ application sources.
//            A grant is held for a whole burst and released on the last
//            byte, on reaching MAX_BURST bytes, or when the granted source
//            stalls (valid low) for TIMEOUT cycles. Every release is followed
//            by at least one IDLE cycle so all sources are re-arbitrated.
// Ports    : clk_i, rst_i        - app clock, synchronous active-high reset
//            req_data_i/valid_i/last_i, req_ready_o - per-requester byte streams
//            in_data_o/in_valid_o, in_ready_i       - to/from usb_cdc IN port
//            grant_o             - registered one-hot grant
//            busy_o              - a grant is active
// Revision : 1.0 - initial release
// ============================================================================
module cdc_in_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 64,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [N_REQ-1:0]     req_last_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [7:0]           in_data_o,
  output logic                 in_valid_o,
  input  logic                 in_ready_i,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 busy_o
);

  localparam int C_PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int C_BCNT_W = $clog2(MAX_BURST + 1);
  // A disabled timeout still needs a 1-bit counter so the register is legal.
  localparam int C_TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [C_BCNT_W-1:0] C_MAX_BURST = C_BCNT_W'(MAX_BURST);
  localparam logic [C_TCNT_W-1:0] C_TIMEOUT   = C_TCNT_W'(TIMEOUT);
  // Last-winner pointer resets to the highest index so requester 0 wins first.
  localparam logic [C_PTR_W-1:0]  C_PTR_RST   = C_PTR_W'(N_REQ - 1);
  localparam logic                C_TMO_EN    = (TIMEOUT != 0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                state_q;
  logic [N_REQ-1:0]      grant_q;
  logic [C_PTR_W-1:0]    ptr_q;
  logic [C_BCNT_W-1:0]   bcnt_q;
  logic [C_TCNT_W-1:0]   tcnt_q;

  logic [N_REQ-1:0]      grant_d;
  logic [C_PTR_W-1:0]    ptr_d;
  logic [C_BCNT_W-1:0]   bcnt_d;
  logic [C_TCNT_W-1:0]   tcnt_d;

  logic [7:0]            w_data;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic                  w_any;
  logic                  w_beat;
  logic                  w_rel_beat;
  logic                  w_rel_tmo;
  int                    w_best;
  int                    w_dist;

  // Datapath mux: grant_q is all-zero in IDLE, so every output collapses to
  // zero there without a separate state qualifier.
  always_comb begin
    w_data      = 8'h00;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) begin
        w_data      = w_data | req_data_i[8*k +: 8];
        w_sel_valid = w_sel_valid | req_valid_i[k];
        w_sel_last  = w_sel_last | req_last_i[k];
      end
    end
  end

  // Round-robin pick: the winner is the valid requester with the smallest
  // forward distance from the last winner (ptr+1 has distance 0).
  always_comb begin
    grant_d = '0;
    ptr_d   = ptr_q;
    w_any   = 1'b0;
    w_best  = N_REQ;
    w_dist  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (req_valid_i[k]) begin
        w_dist = (k > int'(ptr_q)) ? (k - int'(ptr_q) - 1)
                                   : (k + N_REQ - int'(ptr_q) - 1);
        if (w_dist < w_best) begin
          w_best     = w_dist;
          grant_d    = '0;
          grant_d[k] = 1'b1;
          ptr_d      = C_PTR_W'(k);
          w_any      = 1'b1;
        end
      end
    end
  end

  assign bcnt_d     = bcnt_q + 1'b1;
  assign tcnt_d     = tcnt_q + 1'b1;
  assign w_beat     = w_sel_valid & in_ready_i;
  // Last and burst limit on the same beat fold into one release.
  assign w_rel_beat = w_beat & (w_sel_last | (bcnt_d == C_MAX_BURST));
  // Only a missing byte counts as a stall; a NAK (valid high, ready low) never does.
  assign w_rel_tmo  = ~w_sel_valid & C_TMO_EN & (tcnt_d == C_TIMEOUT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= C_PTR_RST;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_any) begin
            state_q <= ST_GRANT;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
          end
        end
        ST_GRANT: begin
          if (w_rel_beat || w_rel_tmo) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
          end else if (w_beat) begin
            bcnt_q <= bcnt_d;
            tcnt_q <= '0;
          end else if (!w_sel_valid) begin
            tcnt_q <= tcnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign in_data_o   = w_data;
  assign in_valid_o  = w_sel_valid;
  assign req_ready_o = grant_q & {N_REQ{in_ready_i}};
  assign grant_o     = grant_q;
  assign busy_o      = (state_q == ST_GRANT);

endmodule
`default_nettype wire

// File: doc/cdc_in_arbiter.md
# cdc_in_arbiter

Packet-granular round-robin arbiter that shares the single USB CDC bulk IN byte stream (`in_data_i`/`in_valid_i`/`in_ready_o` of `usb_cdc`) between N application byte sources, e.g. the loopback echo path and a status/heartbeat generator. It locks the grant to one requester for a whole burst, releasing on last byte, burst limit or stall timeout, so bytes from different sources never interleave within a packet. It sits between the application sources and the `usb_cdc` instance in the app clock domain.

## Interface
- `N_REQ`, 2, number of requesters (2..8).
- `MAX_BURST`, 64, max bytes per grant (matches IN bulk max packet size); ≥1.
- `TIMEOUT`, 16, cycles the granted requester may hold `valid` low before grant is revoked; 0 disables timeout.

- `clk_i`  in  1  app clock; all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_data_i`  in  8*N_REQ  byte from requester k at bits [8k+7:8k].
- `req_valid_i`  in  N_REQ  requester k has a byte.
- `req_last_i`  in  N_REQ  byte is last of requester k's burst; qualified by valid.
- `req_ready_o`  out  N_REQ  byte accepted from requester k this cycle.
- `in_data_o`  out  8  byte to usb_cdc `in_data_i`.
- `in_valid_o`  out  1  to usb_cdc `in_valid_i`.
- `in_ready_i`  in  1  from usb_cdc `in_ready_o`.
- `grant_o`  out  N_REQ  one-hot current grant, registered.
- `busy_o`  out  1  state is GRANT.

## Operation
- States: IDLE, GRANT. Registered: state, `grant_o`, last-winner index `ptr`, burst counter `bcnt` (width $clog2(MAX_BURST+1)), stall counter `tcnt` (width $clog2(TIMEOUT+1)).
- IDLE: if any `req_valid_i` high, pick first requester with valid high searching ptr+1, ptr+2, … modulo N_REQ; next cycle state=GRANT, `grant_o` one-hot winner, ptr=winner, bcnt=0, tcnt=0. No requests: stay IDLE.
- GRANT (winner g), combinational datapath: `in_data_o`=req_data[g], `in_valid_o`=req_valid_i[g], `req_ready_o[g]`=`in_ready_i`; all other `req_ready_o` bits 0. Beat = req_valid_i[g] & in_ready_i.
- On beat: bcnt+1, tcnt=0. If req_last_i[g] or bcnt+1==MAX_BURST: release.
- No beat with req_valid_i[g] low: tcnt+1; if TIMEOUT≠0 and tcnt+1==TIMEOUT: release. Valid high but in_ready_i low (host NAK/FIFO full): tcnt held, never times out.
- Release: next cycle state=IDLE, `grant_o`=0, counters cleared. IDLE always lasts ≥1 cycle (bubble) so other requesters get arbitrated.
- In IDLE: `in_valid_o`=0, `in_data_o`=8'h00, `req_ready_o`=0.
- Requester that is not granted must hold its byte; arbiter never drops or duplicates bytes.
- Released by MAX_BURST mid-message: requester re-competes; round-robin rotation means other pending requesters are served first.

## Timing
- Reset (any state, mid-burst included): state=IDLE, `grant_o`=0, `busy_o`=0, ptr=N_REQ-1 (requester 0 wins first), bcnt=tcnt=0; combinational outputs therefore `in_valid_o`=0, `in_data_o`=0, `req_ready_o`=0 in the cycle after reset edge.
- Request-to-first-beat latency: 1 cycle (valid seen in IDLE at edge t, grant at t+1, byte may transfer in cycle t+1).
- Data path zero-latency, no buffering; full throughput of 1 byte/cycle within a grant.
- Last beat at edge t → IDLE at t+1 → next grant at t+2; min gap between bursts: 1 idle cycle.
- Simultaneous last and MAX_BURST on same beat: single release. Simultaneous release and new requests: new requests arbitrated in the following IDLE cycle.
- `req_last_i` without valid, or on non-granted requester, ignored.

## Test plan
- Single requester 0, 7 bytes 01..07, last on 07, in_ready_i=1 → in_data_o sequence 01..07 on consecutive cycles starting 1 cycle after valid; grant_o=01 for 7 cycles, then 00.
- Both requesters valid continuously, 3-byte bursts each → grant order 0,1,0,1 with 1 idle cycle between bursts; no interleaving within a burst.
- Requester 0 sends 19 bytes, MAX_BURST=16, requester 1 pending → 16 bytes from 0, then requester 1's burst, then remaining 3 bytes from 0.
- in_ready_i low for 256 cycles mid-burst (NAK) with TIMEOUT=16 → grant held, no byte lost; transfer resumes when in_ready_i=1.
- Granted requester drops valid for 16 cycles, TIMEOUT=16 → grant released at cycle 16; with TIMEOUT=0 grant held indefinitely.
- rst_i asserted mid-burst after 5 bytes → next cycle grant_o=0, in_valid_o=0; after release requester 0 wins first and bcnt restarts at 0.
